// File: rtl/interface_frame_sequencer_if.sv
// Frame link bundle between the SPI receive side and interface_frame_sequencer.
// master drives raw frames and e-stop; slave returns latched data and link status.
interface interface_frame_sequencer_if #(
  parameter int BUFFER_SIZE = 240
);
  logic [BUFFER_SIZE-1:0] rx_data;
  logic                   frame_done;
  logic                   estop_in;
  logic [BUFFER_SIZE-1:0] rx_latched;
  logic                   frame_strobe;
  logic                   run;
  logic                   timeout;
  logic [1:0]             state;
  logic [31:0]            header_tx;
  logic [7:0]             bad_frames;

  modport master (
    output rx_data, frame_done, estop_in,
    input  rx_latched, frame_strobe, run, timeout, state, header_tx, bad_frames
  );

  modport slave (
    input  rx_data, frame_done, estop_in,
    output rx_latched, frame_strobe, run, timeout, state, header_tx, bad_frames
  );
endinterface

// File: rtl/interface_frame_sequencer.sv
// Frame qualifier, shadow latch, link watchdog and IDLE/RUN/FAULT/RECOVER sequencer.
// Define FRAME_CHECKSUM_EN to require rx[7:0] == XOR of all other frame bytes.
//
//   state   | meaning
//   IDLE    | out of reset, waiting for the first good frame
//   RUN     | link healthy, joints may be enabled
//   FAULT   | e-stop or link loss, motion inhibited, telemetry still latched
//   RECOVER | counting consecutive good frames before returning to RUN
module interface_frame_sequencer #(
  parameter int          BUFFER_SIZE    = 240,
  parameter logic [31:0] HEADER_RX      = 32'h74697277,
  parameter int          TIMEOUT_CYCLES = 2400000,
  parameter int          RECOVER_FRAMES = 4
) (
  input logic                         sysclk,
  input logic                         rst_n,
  interface_frame_sequencer_if.slave  frm
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W = $clog2(RECOVER_FRAMES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RECOVER_FRAMES);
  localparam logic [31:0] HDR_DATA = 32'h64617461;
  localparam logic [31:0] HDR_ESTP = 32'h65737470;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam int B = BUFFER_SIZE;

  state_t                 state_q, state_d;
  logic [RC_W-1:0]        rc_q, rc_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   wd_expire;
  logic [B-1:0]           rx_latched_q;
  logic                   frame_strobe_q;
  logic                   run_q;
  logic                   timeout_q;
  logic [31:0]            header_tx_q;
  logic [7:0]             bad_frames_q;
  logic [31:0]            hdr;
  logic                   csum_ok;
  logic                   accept;
  logic                   reject;

  // Host sends the header byte-serial, first byte in the MSBs; swap to a word.
  assign hdr = {frm.rx_data[B-25:B-32], frm.rx_data[B-17:B-24],
                frm.rx_data[B-9:B-16],  frm.rx_data[B-1:B-8]};

`ifdef FRAME_CHECKSUM_EN
  localparam int NBYTES = BUFFER_SIZE / 8;
  logic [7:0] xor_acc;

  always_comb begin
    xor_acc = 8'h00;
    for (int i = 1; i < NBYTES; i++) begin
      xor_acc = xor_acc ^ frm.rx_data[i*8 +: 8];
    end
  end

  assign csum_ok = (xor_acc == frm.rx_data[7:0]);
`else
  assign csum_ok = 1'b1;
`endif

  assign accept = frm.frame_done && (hdr == HEADER_RX) && csum_ok;
  assign reject = frm.frame_done && !accept;

  // Expiry is judged on the next count so an accept on that same edge wins.
  always_comb begin
    if (accept) begin
      wd_d = '0;
    end else if (wd_q == WD_MAX) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  assign wd_expire = (wd_d == WD_MAX);

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    if (frm.estop_in) begin
      state_d = ST_FAULT;
      rc_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (wd_expire) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (accept) begin
            state_d = ST_RECOVER;
            rc_d    = RC_W'(1);
          end
        end
        ST_RECOVER: begin
          if (accept) begin
            if ((rc_q + RC_W'(1)) >= RC_MAX) begin
              state_d = ST_RUN;
              rc_d    = '0;
            end else begin
              rc_d = rc_q + RC_W'(1);
            end
          end else if (reject || wd_expire) begin
            state_d = ST_FAULT;
            rc_d    = '0;
          end
        end
        default: begin
          state_d = ST_FAULT;
          rc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rc_q        <= '0;
      run_q       <= 1'b0;
      header_tx_q <= HDR_ESTP;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      run_q       <= (state_d == ST_RUN);
      header_tx_q <= ((state_d == ST_RUN) || (state_d == ST_RECOVER)) ? HDR_DATA : HDR_ESTP;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q           <= '0;
      timeout_q      <= 1'b0;
      rx_latched_q   <= '0;
      frame_strobe_q <= 1'b0;
      bad_frames_q   <= 8'd0;
    end else begin
      wd_q           <= wd_d;
      timeout_q      <= wd_expire;
      frame_strobe_q <= accept;
      if (accept) begin
        rx_latched_q <= frm.rx_data;
      end
      if (reject && (bad_frames_q != 8'hFF)) begin
        bad_frames_q <= bad_frames_q + 8'd1;
      end
    end
  end

  assign frm.rx_latched   = rx_latched_q;
  assign frm.frame_strobe = frame_strobe_q;
  assign frm.run          = run_q;
  assign frm.timeout      = timeout_q;
  assign frm.state        = state_q;
  assign frm.header_tx    = header_tx_q;
  assign frm.bad_frames   = bad_frames_q;

endmodule

// File: tb/tb_interface_frame_sequencer.sv
// Directed bench for interface_frame_sequencer: vector table plus hand-written
// timeout, saturation, checksum and asynchronous-reset sequences.
module tb_interface_frame_sequencer;
  localparam int B = 64;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2, S_REC = 2'd3;
  localparam logic [31:0] GH = 32'h77726974;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  always #5 sysclk = ~sysclk;

  interface_frame_sequencer_if #(.BUFFER_SIZE(B)) frm ();

  interface_frame_sequencer #(
    .BUFFER_SIZE(B),
    .HEADER_RX(32'h74697277),
    .TIMEOUT_CYCLES(100),
    .RECOVER_FRAMES(4)
  ) dut (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .frm(frm)
  );

  typedef struct {
    logic [B-1:0] rx;
    logic         fd;
    logic         es;
    logic [1:0]   st;
    logic [B-1:0] lat;
    logic         stb;
    logic [7:0]   bad;
  } vec_t;

  vec_t vt[16];

  function automatic logic [B-1:0] mk(input logic [31:0] h, input logic [23:0] p, input bit good_x);
    logic [B-1:0] f;
    logic [7:0]   x;
    f = {h, p, 8'h00};
    x = 8'h00;
    for (int i = 1; i < B/8; i++) x = x ^ f[i*8 +: 8];
    if (!good_x) x = x ^ 8'h5A;
    f[7:0] = x;
    return f;
  endfunction

  function automatic logic [31:0] hdr_of(input logic [1:0] st);
    return ((st == S_RUN) || (st == S_REC)) ? 32'h64617461 : 32'h65737470;
  endfunction

  task automatic chk(input string nm, input logic [B-1:0] act, input logic [B-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic to,
                           input logic [B-1:0] lat, input logic stb, input logic [7:0] bad);
    chk({tag, " state"}, B'(frm.state), B'(st));
    chk({tag, " run"}, B'(frm.run), B'(st == S_RUN));
    chk({tag, " header_tx"}, B'(frm.header_tx), B'(hdr_of(st)));
    chk({tag, " timeout"}, B'(frm.timeout), B'(to));
    chk({tag, " rx_latched"}, frm.rx_latched, lat);
    chk({tag, " frame_strobe"}, B'(frm.frame_strobe), B'(stb));
    chk({tag, " bad_frames"}, B'(frm.bad_frames), B'(bad));
  endtask

  task automatic step(input logic [B-1:0] rx, input logic fd, input logic es);
    @(negedge sysclk);
    frm.rx_data    = rx;
    frm.frame_done = fd;
    frm.estop_in   = es;
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst_n          = 1'b0;
    frm.rx_data    = '0;
    frm.frame_done = 1'b0;
    frm.estop_in   = 1'b0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  task automatic setv(input int i, input logic [B-1:0] rx, input logic fd, input logic es,
                      input logic [1:0] st, input logic [B-1:0] lat, input logic stb,
                      input logic [7:0] bad);
    vt[i].rx = rx; vt[i].fd = fd; vt[i].es = es;
    vt[i].st = st; vt[i].lat = lat; vt[i].stb = stb; vt[i].bad = bad;
  endtask

  initial begin
    logic [B-1:0] fa, fbad, fc, fd_, fe, ff, fg, fh, fi, fj, fk, fl, fx;
    fa   = mk(GH, 24'h0A0B0C, 1);
    fbad = mk(32'h00000000, 24'h111111, 1);
    fc   = mk(GH, 24'hC0C0C0, 1);
    fd_  = mk(GH, 24'hD00D01, 1);
    fe   = mk(GH, 24'hE0E0E1, 1);
    ff   = mk(GH, 24'hF00F02, 1);
    fg   = mk(GH, 24'h123123, 1);
    fh   = mk(GH, 24'h456456, 1);
    fi   = mk(GH, 24'h789789, 1);
    fj   = mk(GH, 24'hABCABC, 1);
    fk   = mk(GH, 24'hDEFDEF, 1);
    fl   = mk(GH, 24'h5A5A5A, 1);

    setv(0,  fa,   1, 0, S_RUN,   fa, 1, 0);
    setv(1,  '0,   0, 0, S_RUN,   fa, 0, 0);
    setv(2,  fbad, 1, 0, S_RUN,   fa, 0, 1);
    setv(3,  fc,   1, 0, S_RUN,   fc, 1, 1);
    setv(4,  fd_,  1, 1, S_FAULT, fd_, 1, 1);
    setv(5,  fe,   1, 1, S_FAULT, fe, 1, 1);
    setv(6,  '0,   0, 0, S_FAULT, fe, 0, 1);
    setv(7,  ff,   1, 0, S_REC,   ff, 1, 1);
    setv(8,  fg,   1, 0, S_REC,   fg, 1, 1);
    setv(9,  fh,   1, 0, S_REC,   fh, 1, 1);
    setv(10, fbad, 1, 0, S_FAULT, fh, 0, 2);
    setv(11, fi,   1, 0, S_REC,   fi, 1, 2);
    setv(12, fj,   1, 0, S_REC,   fj, 1, 2);
    setv(13, fk,   1, 0, S_REC,   fk, 1, 2);
    setv(14, fl,   1, 0, S_RUN,   fl, 1, 2);
    setv(15, '0,   0, 0, S_RUN,   fl, 0, 2);

    frm.rx_data    = '0;
    frm.frame_done = 1'b0;
    frm.estop_in   = 1'b0;

    // Reset values, then the vector table
    do_reset();
    check_all("reset", S_IDLE, 0, '0, 0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      step(vt[i].rx, vt[i].fd, vt[i].es);
      check_all($sformatf("vec%0d", i), vt[i].st, 0, vt[i].lat, vt[i].stb, vt[i].bad);
    end

    // Rejected-frame counter saturation
    do_reset();
    step(fa, 1, 0);
    step(fbad, 1, 0);
    check_all("bad1", S_RUN, 0, fa, 0, 8'd1);
    repeat (253) step(fbad, 1, 0);
    chk("bad254", B'(frm.bad_frames), B'(8'd254));
    step(fbad, 1, 0);
    chk("bad255", B'(frm.bad_frames), B'(8'd255));
    step(fbad, 1, 0);
    chk("bad_sat", B'(frm.bad_frames), B'(8'd255));
    chk("bad_sat latched", frm.rx_latched, fa);

    // Watchdog expiry at exactly 100 idle cycles
    do_reset();
    step(fa, 1, 0);
    repeat (99) step('0, 0, 0);
    check_all("wd99", S_RUN, 0, fa, 0, 8'd0);
    step('0, 0, 0);
    check_all("wd100", S_FAULT, 1, fa, 0, 8'd0);
    step('0, 0, 0);
    check_all("wd101", S_FAULT, 1, fa, 0, 8'd0);

    // Good frame on the expiry cycle keeps the link alive
    do_reset();
    step(fa, 1, 0);
    repeat (99) step('0, 0, 0);
    step(fc, 1, 0);
    check_all("wd_save", S_RUN, 0, fc, 1, 8'd0);
    repeat (99) step('0, 0, 0);
    check_all("wd_save99", S_RUN, 0, fc, 0, 8'd0);

    // Checksum byte
    do_reset();
    fx = mk(GH, 24'h123456, 0);
    step(fx, 1, 0);
`ifdef FRAME_CHECKSUM_EN
    check_all("xor_bad", S_IDLE, 0, '0, 0, 8'd1);
`else
    check_all("xor_bad", S_RUN, 0, fx, 1, 8'd0);
`endif
    fx = mk(GH, 24'h123456, 1);
    step(fx, 1, 0);
`ifdef FRAME_CHECKSUM_EN
    check_all("xor_good", S_RUN, 0, fx, 1, 8'd1);
`else
    check_all("xor_good", S_RUN, 0, fx, 1, 8'd0);
`endif

    // Asynchronous reset between edges, frames ignored while held
    do_reset();
    step(fa, 1, 0);
    step(fc, 1, 0);
    check_all("pre_rst", S_RUN, 0, fc, 1, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", S_IDLE, 0, '0, 0, 8'd0);
    step(fa, 1, 0);
    check_all("in_rst", S_IDLE, 0, '0, 0, 8'd0);
    step(fbad, 1, 0);
    check_all("in_rst_bad", S_IDLE, 0, '0, 0, 8'd0);
    @(negedge sysclk);
    frm.frame_done = 1'b0;
    rst_n = 1'b1;
    step('0, 0, 0);
    check_all("post_rst", S_IDLE, 0, '0, 0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
